clause_array_loader: RTL and testbench

- Writer/reader at the far end of the clause-array literal load interface (per-cell wr_i/lit_i in, lit_o out).
- LOAD: accepts a valid/ready stream of clause rows and writes them into the clause array one row per cycle. Any remaining rows are zero-filled so stale literals cannot participate.
- READBACK: scans the array's lit_o outputs row by row and streams them out for learnt-clause spill or debug.

---
 rtl/clause_array_loader.sv | 149 ++++++++++++++
 tb/tb_clause_array_loader.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clause_array_loader.sv
// Loads clause rows into the clause array (zero-filling unused rows) and streams
// the array contents back out row by row.
module clause_array_loader #(
    parameter int unsigned NUM_C   = 8,
    parameter int unsigned NUM_V   = 8,
    parameter int unsigned WIDTH_C = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_load_i,
    input  logic [WIDTH_C:0]          load_cnt_i,
    input  logic                      start_rd_i,
    input  logic                      c_valid_i,
    output logic                      c_ready_o,
    input  logic [2*NUM_V-1:0]        c_lits_i,
    output logic [NUM_C-1:0]          wr_o,
    output logic [2*NUM_V-1:0]        lit_o,
    input  logic [2*NUM_V*NUM_C-1:0]  array_lits_i,
    output logic                      rd_valid_o,
    input  logic                      rd_ready_i,
    output logic [2*NUM_V-1:0]        rd_lits_o,
    output logic [WIDTH_C-1:0]        rd_row_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o
);

    localparam int unsigned RW = 2 * NUM_V;
    localparam logic [WIDTH_C:0]   CntMax  = (WIDTH_C+1)'(NUM_C);
    localparam logic [WIDTH_C-1:0] LastRow = WIDTH_C'(NUM_C - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFill,
        StRd,
        StDone
    } state_e;

    state_e             state_q;
    logic [WIDTH_C-1:0] row_q;
    logic [WIDTH_C:0]   cnt_q;
    logic               err_q;
    logic               rd_valid_q;
    logic [RW-1:0]      rd_lits_q;
    logic [WIDTH_C-1:0] rd_row_q;

    logic               hs_in;
    logic               illegal;
    logic               last_row;
    logic               last_load;
    logic [WIDTH_C:0]   cnt_clamped;

    assign c_ready_o   = (state_q == StLoad);
    assign hs_in       = c_valid_i & c_ready_o;
    assign last_row    = (row_q == LastRow);
    assign last_load   = ({1'b0, row_q} == (cnt_q - 1'b1));
    assign cnt_clamped = (load_cnt_i > CntMax) ? CntMax : load_cnt_i;

    assign busy_o     = (state_q != StIdle);
    assign done_o     = (state_q == StDone);
    assign err_o      = err_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_lits_o  = rd_lits_q;
    assign rd_row_o   = rd_row_q;

    always_comb begin
        illegal = 1'b0;
        for (int j = 0; j < int'(NUM_V); j++) begin
            if (c_lits_i[2*j +: 2] == 2'b11) illegal = 1'b1;
        end
    end

    // Write path is a zero-latency pass-through: the cell captures on the handshake edge.
    always_comb begin
        wr_o  = '0;
        lit_o = '0;
        if (hs_in) begin
            wr_o  = NUM_C'(1) << row_q;
            lit_o = c_lits_i;
        end else if (state_q == StFill) begin
            wr_o  = NUM_C'(1) << row_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            row_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_lits_q  <= '0;
            rd_row_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_load_i) begin
                        err_q   <= 1'b0;
                        row_q   <= '0;
                        cnt_q   <= cnt_clamped;
                        state_q <= (cnt_clamped == '0) ? StFill : StLoad;
                    end else if (start_rd_i) begin
                        row_q      <= '0;
                        rd_valid_q <= 1'b0;
                        state_q    <= StRd;
                    end
                end
                StLoad: begin
                    if (hs_in) begin
                        if (illegal) err_q <= 1'b1;
                        if (last_load) begin
                            if (cnt_q < CntMax) begin
                                row_q   <= row_q + 1'b1;
                                state_q <= StFill;
                            end else begin
                                state_q <= StDone;
                            end
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end
                end
                StFill: begin
                    if (last_row) state_q <= StDone;
                    else          row_q   <= row_q + 1'b1;
                end
                StRd: begin
                    // Alternate select/capture and present/handshake so outputs stay registered.
                    if (!rd_valid_q) begin
                        rd_lits_q  <= array_lits_i[row_q*RW +: RW];
                        rd_row_q   <= row_q;
                        rd_valid_q <= 1'b1;
                    end else if (rd_ready_i) begin
                        rd_valid_q <= 1'b0;
                        if (last_row) state_q <= StDone;
                        else          row_q   <= row_q + 1'b1;
                    end
                end
                StDone: begin
                    row_q   <= '0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_clause_array_loader.sv
// Directed bench for clause_array_loader with scoreboards for array writes and readback rows.
module tb_clause_array_loader;

    logic         clk;
    logic         rst;
    logic         start_load_i;
    logic [3:0]   load_cnt_i;
    logic         start_rd_i;
    logic         c_valid_i;
    logic         c_ready_o;
    logic [15:0]  c_lits_i;
    logic [7:0]   wr_o;
    logic [15:0]  lit_o;
    logic [127:0] array_lits_i;
    logic         rd_valid_o;
    logic         rd_ready_i;
    logic [15:0]  rd_lits_o;
    logic [2:0]   rd_row_o;
    logic         busy_o;
    logic         done_o;
    logic         err_o;

    clause_array_loader #(.NUM_C(8), .NUM_V(8), .WIDTH_C(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_load_i (start_load_i),
        .load_cnt_i   (load_cnt_i),
        .start_rd_i   (start_rd_i),
        .c_valid_i    (c_valid_i),
        .c_ready_o    (c_ready_o),
        .c_lits_i     (c_lits_i),
        .wr_o         (wr_o),
        .lit_o        (lit_o),
        .array_lits_i (array_lits_i),
        .rd_valid_o   (rd_valid_o),
        .rd_ready_i   (rd_ready_i),
        .rd_lits_o    (rd_lits_o),
        .rd_row_o     (rd_row_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  wr;
        logic [15:0] lit;
    } wr_exp_t;

    typedef struct packed {
        logic [2:0]  row;
        logic [15:0] lits;
    } rd_exp_t;

    wr_exp_t wr_q[$];
    rd_exp_t rd_q[$];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc;
    int done_cyc;
    int ready_seen;
    int rd_hs;
    bit done_flag;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample at the falling edge, score outputs, then advance to just after the next rising edge.
    task automatic step();
        wr_exp_t we;
        rd_exp_t re;
        @(negedge clk);
        if (c_ready_o) ready_seen++;
        if (done_o) begin
            done_flag = 1'b1;
            done_cyc  = cyc;
        end
        if (wr_o !== 8'h00) begin
            if (wr_q.size() == 0) begin
                check("wr_unexpected", {24'h0, wr_o}, 32'h0);
            end else begin
                we = wr_q.pop_front();
                check("wr_strobe", {24'h0, wr_o}, {24'h0, we.wr});
                check("wr_lit", {16'h0, lit_o}, {16'h0, we.lit});
            end
        end
        if (rd_valid_o === 1'b1) begin
            if (rd_q.size() == 0) begin
                check("rd_unexpected", {31'h0, rd_valid_o}, 32'h0);
            end else begin
                re = rd_q[0];
                check("rd_row", {29'h0, rd_row_o}, {29'h0, re.row});
                check("rd_lits", {16'h0, rd_lits_o}, {16'h0, re.lits});
                if (rd_ready_i) begin
                    void'(rd_q.pop_front());
                    rd_hs++;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to_done(input int budget);
        done_flag = 1'b0;
        for (int i = 0; i < budget && !done_flag; i++) step();
        check("done_timeout", {31'h0, done_flag}, 32'h1);
    endtask

    task automatic push_wr(input logic [7:0] wr, input logic [15:0] lit);
        wr_q.push_back('{wr: wr, lit: lit});
    endtask

    initial begin
        rst          = 1'b0;
        start_load_i = 1'b0;
        load_cnt_i   = '0;
        start_rd_i   = 1'b0;
        c_valid_i    = 1'b0;
        c_lits_i     = '0;
        rd_ready_i   = 1'b0;
        for (int r = 0; r < 8; r++) array_lits_i[r*16 +: 16] = 16'(r * 16'h1111);

        // Reset state
        #3;
        check("rst_wr", {24'h0, wr_o}, 32'h0);
        check("rst_lit", {16'h0, lit_o}, 32'h0);
        check("rst_flags", {26'h0, c_ready_o, rd_valid_o, busy_o, done_o, err_o, 1'b0}, 32'h0);
        check("rst_rd", {13'h0, rd_row_o, rd_lits_o}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Load 3 rows then 5 zero-fill rows
        push_wr(8'h01, 16'h5555);
        push_wr(8'h02, 16'hAAAA);
        push_wr(8'h04, 16'h0001);
        for (int r = 3; r < 8; r++) push_wr(8'(1 << r), 16'h0);
        start_cyc    = cyc;
        start_load_i = 1'b1;
        load_cnt_i   = 4'd3;
        c_valid_i    = 1'b1;
        c_lits_i     = 16'h5555;
        step();
        start_load_i = 1'b0;
        step();
        c_lits_i = 16'hAAAA;
        step();
        c_lits_i = 16'h0001;
        step();
        c_valid_i = 1'b0;
        run_to_done(20);
        check("load3_done_latency", 32'(done_cyc - start_cyc), 32'd9);
        check("load3_err", {31'h0, err_o}, 32'h0);
        check("load3_queue", 32'(wr_q.size()), 32'h0);

        // Backpressure: valid 1,0,1,0,...; illegal junk while invalid must be ignored
        push_wr(8'h01, 16'h1111);
        push_wr(8'h02, 16'h2222);
        push_wr(8'h04, 16'h4444);
        push_wr(8'h08, 16'h0101);
        for (int r = 4; r < 8; r++) push_wr(8'(1 << r), 16'h0);
        start_load_i = 1'b1;
        load_cnt_i   = 4'd4;
        step();
        start_load_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            c_valid_i = 1'b1;
            case (i)
                0: c_lits_i = 16'h1111;
                1: c_lits_i = 16'h2222;
                2: c_lits_i = 16'h4444;
                default: c_lits_i = 16'h0101;
            endcase
            step();
            c_valid_i = 1'b0;
            c_lits_i  = 16'hFFFF;
            if (i < 3) begin
                check("bp_ready_stall", {31'h0, c_ready_o}, 32'h1);
                step();
            end
        end
        run_to_done(20);
        check("bp_err", {31'h0, err_o}, 32'h0);
        check("bp_queue", 32'(wr_q.size()), 32'h0);

        // Illegal literal: row still written, sticky error
        push_wr(8'h01, 16'h0003);
        for (int r = 1; r < 8; r++) push_wr(8'(1 << r), 16'h0);
        start_load_i = 1'b1;
        load_cnt_i   = 4'd1;
        step();
        start_load_i = 1'b0;
        c_valid_i    = 1'b1;
        c_lits_i     = 16'h0003;
        check("ill_err_before", {31'h0, err_o}, 32'h0);
        step();
        c_valid_i = 1'b0;
        check("ill_err_next", {31'h0, err_o}, 32'h1);
        run_to_done(20);
        check("ill_err_sticky", {31'h0, err_o}, 32'h1);

        // cnt=0: eight zero-fill writes, never ready; start clears err
        for (int r = 0; r < 8; r++) push_wr(8'(1 << r), 16'h0);
        ready_seen   = 0;
        start_cyc    = cyc;
        start_load_i = 1'b1;
        load_cnt_i   = 4'd0;
        c_valid_i    = 1'b1;
        c_lits_i     = 16'hFFFF;
        step();
        start_load_i = 1'b0;
        check("cnt0_err_cleared", {31'h0, err_o}, 32'h0);
        run_to_done(20);
        c_valid_i = 1'b0;
        check("cnt0_ready_seen", 32'(ready_seen), 32'h0);
        check("cnt0_done_latency", 32'(done_cyc - start_cyc), 32'd9);
        check("cnt0_err", {31'h0, err_o}, 32'h0);
        check("cnt0_queue", 32'(wr_q.size()), 32'h0);

        // cnt=9 clamps to 8 loaded rows with no fill
        for (int r = 0; r < 8; r++) push_wr(8'(1 << r), 16'(16'h0001 << (2 * r)));
        start_cyc    = cyc;
        start_load_i = 1'b1;
        load_cnt_i   = 4'd9;
        c_valid_i    = 1'b1;
        c_lits_i     = 16'h0001;
        step();
        start_load_i = 1'b0;
        for (int r = 0; r < 8; r++) begin
            c_lits_i = 16'(16'h0001 << (2 * r));
            step();
        end
        c_valid_i = 1'b0;
        run_to_done(5);
        check("cnt9_done_latency", 32'(done_cyc - start_cyc), 32'd9);
        check("cnt9_queue", 32'(wr_q.size()), 32'h0);

        // Readback with a 2-cycle stall while row 4 is presented
        for (int r = 0; r < 8; r++) rd_q.push_back('{row: 3'(r), lits: 16'(r * 16'h1111)});
        rd_hs      = 0;
        rd_ready_i = 1'b1;
        start_rd_i = 1'b1;
        step();
        start_rd_i = 1'b0;
        for (int i = 0; i < 9; i++) step();
        rd_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #2;
            check("rd_stall_valid", {31'h0, rd_valid_o}, 32'h1);
            check("rd_stall_row", {29'h0, rd_row_o}, 32'h4);
            check("rd_stall_lits", {16'h0, rd_lits_o}, 32'h4444);
            step();
        end
        rd_ready_i = 1'b1;
        run_to_done(40);
        check("rd_handshakes", 32'(rd_hs), 32'd8);
        check("rd_queue", 32'(rd_q.size()), 32'h0);

        // Simultaneous starts load only; starts while busy are ignored
        for (int r = 0; r < 8; r++) push_wr(8'(1 << r), 16'h0);
        rd_hs        = 0;
        start_load_i = 1'b1;
        start_rd_i   = 1'b1;
        load_cnt_i   = 4'd0;
        step();
        start_load_i = 1'b0;
        start_rd_i   = 1'b0;
        step();
        start_load_i = 1'b1;
        start_rd_i   = 1'b1;
        load_cnt_i   = 4'd3;
        step();
        start_load_i = 1'b0;
        start_rd_i   = 1'b0;
        run_to_done(20);
        step();
        check("simul_busy_idle", {31'h0, busy_o}, 32'h0);
        check("simul_no_rd", 32'(rd_hs), 32'h0);
        check("simul_queue", 32'(wr_q.size()), 32'h0);

        // Async reset in the middle of row 2 of a load
        push_wr(8'h01, 16'h1515);
        push_wr(8'h02, 16'h2626);
        start_load_i = 1'b1;
        load_cnt_i   = 4'd4;
        c_valid_i    = 1'b1;
        c_lits_i     = 16'h1515;
        step();
        start_load_i = 1'b0;
        step();
        c_lits_i = 16'h2626;
        step();
        c_lits_i = 16'h1919;
        #1;
        check("arst_pre_wr", {24'h0, wr_o}, 32'h04);
        rst = 1'b0;
        #1;
        check("arst_wr", {24'h0, wr_o}, 32'h0);
        check("arst_busy", {31'h0, busy_o}, 32'h0);
        check("arst_ready", {31'h0, c_ready_o}, 32'h0);
        c_valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("arst_queue", 32'(wr_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
